// File: rtl/wb_stream_writer.sv
// -----------------------------------------------------------------------------
// wb_stream_writer
//
// Wishbone write master that packs an 8-bit valid/ready byte stream into
// DATA_WIDTH-bit words and writes them to consecutive word-aligned addresses
// of a Wishbone slave memory. A transfer is started from IDLE with a base
// address and a word limit; it ends on the word limit, on a byte carrying
// s_tlast, or on a slave error. A short final word only enables the lanes it
// actually filled.
//
// Build option:
//   WB_STREAM_WRITER_BIG_ENDIAN_EN  when defined, the first stream byte of a
//                                   word goes to lane SELECT_WIDTH-1 and later
//                                   bytes descend; otherwise the first byte
//                                   goes to lane 0 (little-endian).
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start_i                begin a transfer (sampled only in IDLE)
//   base_adr_i             byte address of the first word (low bits ignored)
//   max_words_i            word limit, 0 completes immediately
//   s_tdata/s_tvalid/s_tready/s_tlast   input byte stream
//   adr_o/dat_o/we_o/sel_o/stb_o/cyc_o  Wishbone master outputs
//   ack_i/err_i            Wishbone slave responses
//   busy_o                 high whenever not IDLE
//   done_o                 one-cycle completion pulse
//   error_o                sticky slave-error flag, cleared by the next start
//   count_o                words acknowledged in the current/last transfer
// -----------------------------------------------------------------------------
module wb_stream_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_adr_i,
    input  logic [ADDR_WIDTH-1:0]   max_words_i,
    input  logic [7:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [ADDR_WIDTH-1:0]   count_o
);

    localparam int PTR_W = (SELECT_WIDTH > 1) ? $clog2(SELECT_WIDTH) : 1;
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(SELECT_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [ADDR_WIDTH-1:0]   limit_q, limit_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   count_inc;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        lane;
    logic                    last_q, last_d;
    logic                    error_q, error_d;

    // The byte pointer counts bytes within the word; lane maps it onto the
    // physical byte lane according to the configured byte order.
`ifdef WB_STREAM_WRITER_BIG_ENDIAN_EN
    assign lane = PTR_LAST - ptr_q;
`else
    assign lane = ptr_q;
`endif

    assign count_inc = count_q + ADDR_WIDTH'(1);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        limit_d = limit_q;
        count_d = count_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        error_d = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    adr_d   = base_adr_i & ADR_MASK;
                    limit_d = max_words_i;
                    count_d = '0;
                    error_d = 1'b0;
                    ptr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    last_d  = 1'b0;
                    state_d = (max_words_i == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (s_tvalid) begin
                    dat_d[8*int'(lane) +: 8] = s_tdata;
                    sel_d[lane]              = 1'b1;
                    ptr_d                    = ptr_q + PTR_W'(1);
                    last_d                   = s_tlast;
                    if (s_tlast || ptr_q == PTR_LAST) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // An error response wins over a simultaneous acknowledge and
                // leaves the word count untouched.
                if (err_i) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (ack_i) begin
                    count_d = count_inc;
                    adr_d   = adr_q + ADR_STEP;
                    dat_d   = '0;
                    sel_d   = '0;
                    ptr_d   = '0;
                    state_d = (last_q || count_inc == limit_q) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its next-state input, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            limit_q <= '0;
            count_q <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            limit_q <= limit_d;
            count_q <= count_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            error_q <= error_d;
        end
    end

    // Bus and status strobes decode straight from the state register, so an
    // asynchronous reset drops an in-flight Wishbone cycle immediately.
    assign cyc_o    = (state_q == S_WRITE);
    assign stb_o    = cyc_o;
    assign we_o     = cyc_o;
    assign s_tready = (state_q == S_FILL);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign adr_o    = adr_q;
    assign dat_o    = dat_q;
    assign sel_o    = sel_q;
    assign error_o  = error_q;
    assign count_o  = count_q;

endmodule
